// File: rtl/input_debouncer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | input_debouncer: 2-flop sync + debounce for WIDTH switches and the step  |
// | button, change strobe and step pulses. Macro BTN_AUTOREPEAT_EN enables   |
// | hold-to-repeat. Rev 1.0                                                  |
// +--------------------------------------------------------------------------+
module input_debouncer #(
  parameter int WIDTH         = 8,
  parameter int DB_CYCLES     = 250000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000,
  parameter int CNT_W         = 26
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic [WIDTH-1:0] iSwitch,
  input  logic             iBtn,
  output logic [WIDTH-1:0] oSwitch,
  output logic             oSwChange,
  output logic             oBtnLevel,
  output logic             oBtnPulse
);

  localparam int              C_NCH = WIDTH + 1;
  localparam logic [CNT_W-1:0] C_DB  = CNT_W'(DB_CYCLES);
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  logic [C_NCH-1:0] w_raw;
  logic [C_NCH-1:0] w_stable;
  logic [C_NCH-1:0] w_flip;
  logic             w_btn_rise;
  logic             w_btn_fall;
  logic             r_sw_change;
  logic             r_btn_pulse;

  // Button rides along as the top channel so it shares the debounce logic.
  assign w_raw = {iBtn, iSwitch};

  for (genvar gi = 0; gi < C_NCH; gi++) begin : g_ch
    logic             r_s1;
    logic             r_s2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_cnt_inc    = r_cnt + C_ONE;
    assign w_flip[gi]   = (r_s2 != r_stable) && (w_cnt_inc == C_DB);
    assign w_stable[gi] = r_stable;

    always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
        r_s1     <= 1'b0;
        r_s2     <= 1'b0;
        r_stable <= 1'b0;
        r_cnt    <= '0;
      end else begin
        r_s1 <= w_raw[gi];
        r_s2 <= r_s1;
        if (r_s2 == r_stable) begin
          r_cnt <= '0;
        end else if (w_flip[gi]) begin
          r_stable <= r_s2;
          r_cnt    <= '0;
        end else begin
          r_cnt <= w_cnt_inc;
        end
      end
    end
  end

  assign w_btn_rise = w_flip[WIDTH] & ~w_stable[WIDTH];
  assign w_btn_fall = w_flip[WIDTH] &  w_stable[WIDTH];

  // Registered from the flip events so the strobe lines up with the new level.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) r_sw_change <= 1'b0;
    else      r_sw_change <= |w_flip[WIDTH-1:0];
  end

`ifdef BTN_AUTOREPEAT_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] C_RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_rc;
  logic [CNT_W-1:0] w_rc_nxt;
  logic             w_pulse_nxt;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state     <= ST_IDLE;
      r_rc        <= '0;
      r_btn_pulse <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rc        <= w_rc_nxt;
      r_btn_pulse <= w_pulse_nxt;
    end
  end

  // Release has priority over a repeat falling due on the same edge.
  always_comb begin
    w_state_nxt = r_state;
    w_rc_nxt    = '0;
    w_pulse_nxt = 1'b0;
    if (w_btn_fall) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_btn_rise) begin
            w_state_nxt = ST_DELAY;
            w_pulse_nxt = 1'b1;
          end
        end
        ST_DELAY: begin
          if (r_rc == C_RD_LAST) begin
            w_state_nxt = ST_REPEAT;
            w_pulse_nxt = 1'b1;
          end else begin
            w_rc_nxt = r_rc + C_ONE;
          end
        end
        ST_REPEAT: begin
          if (r_rc == C_RP_LAST) w_pulse_nxt = 1'b1;
          else                   w_rc_nxt    = r_rc + C_ONE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end
`else
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_pulse_nxt;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state     <= ST_IDLE;
      r_btn_pulse <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_btn_pulse <= w_pulse_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pulse_nxt = 1'b0;
    if (w_btn_fall) begin
      w_state_nxt = ST_IDLE;
    end else if ((r_state == ST_IDLE) && w_btn_rise) begin
      w_state_nxt = ST_HELD;
      w_pulse_nxt = 1'b1;
    end
  end
`endif

  assign oSwitch   = w_stable[WIDTH-1:0];
  assign oBtnLevel = w_stable[WIDTH];
  assign oSwChange = r_sw_change;
  assign oBtnPulse = r_btn_pulse;

endmodule

`default_nettype wire

// File: tb/tb_input_debouncer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_input_debouncer: scoreboard bench for input_debouncer (small counts). |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_input_debouncer;

  localparam int WIDTH = 8;
  localparam int DB    = 4;
  localparam int RD    = 10;
  localparam int RP    = 3;
  localparam int CW    = 8;

  logic             iClk = 1'b0;
  logic             iRst = 1'b1;
  logic [WIDTH-1:0] iSwitch = '0;
  logic             iBtn = 1'b0;
  logic [WIDTH-1:0] oSwitch;
  logic             oSwChange;
  logic             oBtnLevel;
  logic             oBtnPulse;

  input_debouncer #(
    .WIDTH(WIDTH), .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .CNT_W(CW)
  ) dut (
    .iClk(iClk), .iRst(iRst), .iSwitch(iSwitch), .iBtn(iBtn),
    .oSwitch(oSwitch), .oSwChange(oSwChange), .oBtnLevel(oBtnLevel), .oBtnPulse(oBtnPulse)
  );

  always #5 iClk = ~iClk;

  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [WIDTH-1:0] val; } ev_t;
  typedef struct { int cyc; logic val; } bev_t;

  ev_t  sw_q[$];
  bev_t lvl_q[$];
  int   btn_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic [WIDTH-1:0] m_sw = '0;
  logic             m_btn = 1'b0;

  task automatic test_reset();
    ev_t e;
    iRst = 1'b1; iSwitch = 8'hA5; iBtn = 1'b0;
    repeat (3) begin
      @(negedge iClk);
      n_cmp++;
      if (oSwitch !== 8'h00 || oSwChange !== 1'b0 || oBtnLevel !== 1'b0 || oBtnPulse !== 1'b0) begin
        n_err++;
        $display("FAIL reset_state: sw=%h chg=%b lvl=%b pls=%b, required all zero", oSwitch, oSwChange, oBtnLevel, oBtnPulse);
      end
    end
    iRst = 1'b0;
    m_sw = '0;
    e.cyc = cyc + DB + 2; e.val = 8'hA5; sw_q.push_back(e);
    for (int i = 0; i < 12; i++) begin
      @(negedge iClk);
      n_cmp++;
      if (sw_q.size() > 0 && sw_q[0].cyc == cyc) begin
        m_sw = sw_q[0].val; void'(sw_q.pop_front());
        if (oSwChange !== 1'b1 || oSwitch !== m_sw) begin
          n_err++;
          $display("FAIL reset_release @%0d: sw=%h chg=%b, required sw=%h chg=1", cyc, oSwitch, oSwChange, m_sw);
        end
      end else if (oSwChange !== 1'b0 || oSwitch !== m_sw) begin
        n_err++;
        $display("FAIL reset_release_hold @%0d: sw=%h chg=%b, required sw=%h chg=0", cyc, oSwitch, oSwChange, m_sw);
      end
    end
    n_cmp++;
    if (sw_q.size() != 0) begin
      n_err++;
      $display("FAIL reset_pending: %0d events unseen, required 0", sw_q.size());
      sw_q.delete();
    end
  endtask

  task automatic test_bounce();
    ev_t  e;
    logic b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 0) begin
        iSwitch = 8'h00;
        e.cyc = cyc + DB + 2; e.val = 8'h00; sw_q.push_back(e);
      end
      if (i >= 10) begin
        // pairs 1,1,0,0,1,1,0,0 then held at 1
        b0 = (i >= 18) ? 1'b1 : ((((i - 10) / 2) % 2) == 0);
        iSwitch = {7'd0, b0};
        if (i == 18) begin
          e.cyc = cyc + DB + 2; e.val = 8'h01; sw_q.push_back(e);
        end
      end
      @(negedge iClk);
      n_cmp++;
      if (sw_q.size() > 0 && sw_q[0].cyc == cyc) begin
        m_sw = sw_q[0].val; void'(sw_q.pop_front());
        if (oSwChange !== 1'b1 || oSwitch !== m_sw) begin
          n_err++;
          $display("FAIL bounce_update @%0d: sw=%h chg=%b, required sw=%h chg=1", cyc, oSwitch, oSwChange, m_sw);
        end
      end else if (oSwChange !== 1'b0 || oSwitch !== m_sw) begin
        n_err++;
        $display("FAIL bounce_hold @%0d: sw=%h chg=%b, required sw=%h chg=0", cyc, oSwitch, oSwChange, m_sw);
      end
    end
    n_cmp++;
    if (sw_q.size() != 0) begin
      n_err++;
      $display("FAIL bounce_pending: %0d events unseen, required 0", sw_q.size());
      sw_q.delete();
    end
  endtask

  task automatic test_simultaneous();
    ev_t e;
    for (int i = 0; i < 30; i++) begin
      if (i == 0 || i == 10 || i == 20) begin
        iSwitch = (i == 10) ? 8'hFF : 8'h00;
        e.cyc = cyc + DB + 2; e.val = iSwitch; sw_q.push_back(e);
      end
      @(negedge iClk);
      n_cmp++;
      if (sw_q.size() > 0 && sw_q[0].cyc == cyc) begin
        m_sw = sw_q[0].val; void'(sw_q.pop_front());
        if (oSwChange !== 1'b1 || oSwitch !== m_sw) begin
          n_err++;
          $display("FAIL simul_update @%0d: sw=%h chg=%b, required sw=%h chg=1", cyc, oSwitch, oSwChange, m_sw);
        end
      end else if (oSwChange !== 1'b0 || oSwitch !== m_sw) begin
        n_err++;
        $display("FAIL simul_hold @%0d: sw=%h chg=%b, required sw=%h chg=0", cyc, oSwitch, oSwChange, m_sw);
      end
    end
    n_cmp++;
    if (sw_q.size() != 0) begin
      n_err++;
      $display("FAIL simul_pending: %0d events unseen, required 0", sw_q.size());
      sw_q.delete();
    end
  endtask

  task automatic test_btn_hold();
    bev_t e;
    int   t0;
    int   tf;
    logic exp_p;
    for (int i = 0; i < 72; i++) begin
      if (i == 0) begin
        iBtn = 1'b1;
        t0 = cyc + DB + 2;
        tf = t0 + 46;
        e.cyc = t0; e.val = 1'b1; lvl_q.push_back(e);
        btn_q.push_back(t0);
`ifdef BTN_AUTOREPEAT_EN
        // a repeat due on the release cycle is suppressed
        for (int t = t0 + RD; t < tf; t += RP) btn_q.push_back(t);
`endif
      end
      if (i == 46) begin
        iBtn = 1'b0;
        e.cyc = cyc + DB + 2; e.val = 1'b0; lvl_q.push_back(e);
      end
      @(negedge iClk);
      n_cmp++;
      exp_p = (btn_q.size() > 0 && btn_q[0] == cyc);
      if (exp_p) void'(btn_q.pop_front());
      if (lvl_q.size() > 0 && lvl_q[0].cyc == cyc) begin
        m_btn = lvl_q[0].val; void'(lvl_q.pop_front());
      end
      if (oBtnPulse !== exp_p || oBtnLevel !== m_btn) begin
        n_err++;
        $display("FAIL btn_hold @%0d (t0=%0d): pls=%b lvl=%b, required pls=%b lvl=%b", cyc, t0, oBtnPulse, oBtnLevel, exp_p, m_btn);
      end
    end
    n_cmp++;
    if (btn_q.size() != 0 || lvl_q.size() != 0) begin
      n_err++;
      $display("FAIL btn_hold_pending: %0d pulses %0d levels unseen, required 0", btn_q.size(), lvl_q.size());
      btn_q.delete(); lvl_q.delete();
    end
  endtask

  task automatic test_reset_in_repeat();
    bev_t e;
    int   t0;
    logic exp_p;
    for (int i = 0; i < 50; i++) begin
      if (i == 0) begin
        iBtn = 1'b1;
        t0 = cyc + DB + 2;
        e.cyc = t0; e.val = 1'b1; lvl_q.push_back(e);
        btn_q.push_back(t0);
`ifdef BTN_AUTOREPEAT_EN
        btn_q.push_back(t0 + RD);
`endif
      end
      if (i == 18) begin
        iRst = 1'b1;
        #1;
        n_cmp++;
        if (oBtnPulse !== 1'b0 || oBtnLevel !== 1'b0) begin
          n_err++;
          $display("FAIL rst_abort @%0d: pls=%b lvl=%b, required 0 0", cyc, oBtnPulse, oBtnLevel);
        end
        m_btn = 1'b0;
      end
      if (i == 21) begin
        iRst = 1'b0;
        e.cyc = cyc + DB + 2; e.val = 1'b1; lvl_q.push_back(e);
        btn_q.push_back(cyc + DB + 2);
      end
      if (i == 30) begin
        iBtn = 1'b0;
        e.cyc = cyc + DB + 2; e.val = 1'b0; lvl_q.push_back(e);
      end
      @(negedge iClk);
      n_cmp++;
      exp_p = (btn_q.size() > 0 && btn_q[0] == cyc);
      if (exp_p) void'(btn_q.pop_front());
      if (lvl_q.size() > 0 && lvl_q[0].cyc == cyc) begin
        m_btn = lvl_q[0].val; void'(lvl_q.pop_front());
      end
      if (oBtnPulse !== exp_p || oBtnLevel !== m_btn) begin
        n_err++;
        $display("FAIL rst_repeat @%0d (t0=%0d): pls=%b lvl=%b, required pls=%b lvl=%b", cyc, t0, oBtnPulse, oBtnLevel, exp_p, m_btn);
      end
    end
    n_cmp++;
    if (btn_q.size() != 0 || lvl_q.size() != 0) begin
      n_err++;
      $display("FAIL rst_repeat_pending: %0d pulses %0d levels unseen, required 0", btn_q.size(), lvl_q.size());
      btn_q.delete(); lvl_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_simultaneous();
    test_btn_hold();
    test_reset_in_repeat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
